shift_iter: RTL and testbench
=============================

Name: shift_iter

Overview:
- Multi-cycle 16-bit shifter/rotator for the execute stage.
- Resolves one barrel stage per clock (shift by 1, 2, 4, then 8), using a registered datapath and one active stage per cycle instead of a four-deep combinational mux chain.
- Accepts an operand, amount and opcode with a start pulse; returns the result with a one-cycle done strobe.
- Sits between the decode/operand-select logic (upstream) and the ALU result mux (downstream).

Parameters:
- WIDTH, 16, data width; only 16 is supported.
- CNTW, 4, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only when idle or done.
- in  input  16  operand.
- cnt  input  4  shift amount, 0 to 15.
- op  input  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
- busy  output  1  high while shifting; registered.
- done  output  1  one-cycle result-valid strobe; registered.
- out  output  16  result register; holds its value until the next result.

Behaviour:
- Clocking and reset: one clock, reset asynchronous and active-low.
  - rst_n low forces state=IDLE, out=0x0000, busy=0, done=0, internal data/cnt/op/stage registers = 0.
  - Release is synchronous to the next edge.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge E0 latches in into the data register, cnt and op into shadow registers, stage=0, and moves to SHIFT. busy=1 from E0.
- SHIFT: at each edge, data <= stage_k(data), k = stage.
  - If cnt_shadow[k]=0, data is unchanged.
  - If cnt_shadow[k]=1, data is shifted by 2^k:
    - SLL: zero fill on the right.
    - SRA: replicate bit 15 on the left.
    - ROL/ROR: bits that leave one end re-enter at the other.
  - stage increments 0 to 3.
  - At the edge applying stage 3 (E4): out <= final data, busy <= 0, done <= 1, state <= DONE.
- DONE: lasts exactly one cycle; done=1.
  - If start=1 at edge E5: same latch action as IDLE, go to SHIFT, done <= 0, busy <= 1. Back-to-back operations are allowed.
  - Otherwise go to IDLE, done <= 0.
- Latency: fixed. start sampled at E0, done high in the cycle after E4, i.e. 4 cycles after acceptance, independent of cnt (cnt=0 still takes 4 cycles and returns out=in).
- start while in SHIFT is ignored. in/cnt/op changes during SHIFT have no effect, because the shadow registers are used.
- out changes only at the E4 edge. It keeps its last value through IDLE, the following SHIFT, and unrelated start pulses.
- Reset asserted mid-SHIFT aborts immediately to the reset values. No done is produced for the aborted operation.
- No X propagation: op and cnt are fully decoded, so all 4 op codes are valid.

Test Plan:
- SLL: in=0x0001, cnt=15, op=01, start at E0 -> busy=1 for E0 to E4; done=1 in exactly one cycle after E4; out=0x8000.
- SRA and SRL-style fill: in=0x8000, cnt=4, op=11 -> out=0xF800. Then in=0x7FF0, cnt=4, op=11 -> out=0x07FF.
- Rotates:
  - in=0x1234, cnt=4, op=00 -> out=0x2341.
  - in=0x0001, cnt=1, op=10 -> out=0x8000.
  - in=0xA5C3, cnt=0, any op -> out=0xA5C3 with the same 4-cycle latency.
- Back-to-back:
  - start held high across the DONE cycle with a second operation (in=0x00FF, cnt=8, op=01) -> first result visible, second done 5 cycles after the first done, out=0xFF00.
  - A start pulse during SHIFT with different operands -> ignored; the result matches the first operation only.
- Reset mid-operation: assert rst_n=0 two cycles after start -> busy, done and out are 0 immediately (asynchronous, no clock edge needed). After release with start=0, no done ever fires. A new start then completes normally.

Source files
------------

// File: rtl/shift_iter.sv
// Multi-cycle 16-bit shifter/rotator: one barrel stage (1, 2, 4, 8) per clock,
// fixed four-cycle latency from acceptance to the done strobe.
module shift_iter #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNTW-1:0]  cnt,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data;
    logic [CNTW-1:0]  cnt_q;
    logic [1:0]       op_q;
    logic [1:0]       stage;
    logic             load;
    logic             finish;
    logic [WIDTH-1:0] shifted;

    // Single barrel stage k: shift by 2^k when enabled, otherwise pass through.
    function automatic logic [WIDTH-1:0] stage_fn(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       k,
        input logic [1:0]       o,
        input logic             en
    );
        int unsigned      sh;
        logic [WIDTH-1:0] r;
        sh = 32'd1 << k;
        r  = d;
        if (en) begin
            case (o)
                OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
                OP_SLL:  r = d << sh;
                OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
                OP_SRA:  r = $signed(d) >>> sh;
                default: r = d;
            endcase
        end
        return r;
    endfunction

    assign shifted = stage_fn(data, stage, op_q, cnt_q[stage]);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (stage == 2'd3) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are shadowed at acceptance so upstream changes mid-shift are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            cnt_q <= '0;
            op_q  <= '0;
            stage <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                data  <= in;
                cnt_q <= cnt;
                op_q  <= op;
                stage <= '0;
                busy  <= 1'b1;
                done  <= 1'b0;
            end else if (state == SHIFT) begin
                data  <= shifted;
                stage <= stage + 2'd1;
                if (finish) begin
                    out  <= shifted;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_iter.sv
// Directed self-checking bench for shift_iter: latency, all opcodes, back-to-back,
// ignored mid-shift start and asynchronous reset abort.
module tb_shift_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int          checks;
    int          fails;
    logic [15:0] last_out;
    int          done_seen;

    shift_iter #(.WIDTH(16), .CNTW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in),
        .cnt   (cnt),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Presents an operation and returns just after the accepting edge with start dropped.
    task automatic applyStimulus(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o);
        @(negedge clk);
        in    = i;
        cnt   = c;
        op    = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [15:0] i, input logic [3:0] c,
                         input logic [1:0] o, input logic [15:0] exp);
        applyStimulus(i, c, o);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput({tag, " busy"}, 16'(busy), 16'd1);
            checkOutput({tag, " done early"}, 16'(done), 16'd0);
            checkOutput({tag, " out hold"}, out, last_out);
        end
        @(negedge clk);
        checkOutput({tag, " done"}, 16'(done), 16'd1);
        checkOutput({tag, " busy low"}, 16'(busy), 16'd0);
        checkOutput({tag, " result"}, out, exp);
        last_out = exp;
        @(negedge clk);
        checkOutput({tag, " done pulse"}, 16'(done), 16'd0);
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        last_out = 16'h0000;
        rst_n    = 1'b0;
        start    = 1'b0;
        in       = 16'h0000;
        cnt      = 4'd0;
        op       = 2'b00;

        #12;
        checkOutput("reset busy", 16'(busy), 16'd0);
        checkOutput("reset done", 16'(done), 16'd0);
        checkOutput("reset out", out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("sll15", 16'h0001, 4'd15, 2'b01, 16'h8000);
        runOp("sra neg", 16'h8000, 4'd4, 2'b11, 16'hF800);
        runOp("sra pos", 16'h7FF0, 4'd4, 2'b11, 16'h07FF);
        runOp("rol4", 16'h1234, 4'd4, 2'b00, 16'h2341);
        runOp("ror1", 16'h0001, 4'd1, 2'b10, 16'h8000);
        for (int k = 0; k < 4; k++) begin
            runOp($sformatf("cnt0 op%0d", k), 16'hA5C3, 4'd0, 2'(k), 16'hA5C3);
        end
        runOp("rol15", 16'h8001, 4'd15, 2'b00, 16'hC000);
        runOp("ror8", 16'h12F0, 4'd8, 2'b10, 16'hF012);

        repeat (3) @(negedge clk);
        checkOutput("idle hold", out, last_out);

        // Back-to-back: start held through SHIFT and DONE, operands swapped mid-shift.
        @(negedge clk);
        in    = 16'h1234;
        cnt   = 4'd4;
        op    = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        in  = 16'h00FF;
        cnt = 4'd8;
        op  = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("b2b first busy", 16'(busy), 16'd1);
            checkOutput("b2b first done early", 16'(done), 16'd0);
        end
        @(negedge clk);
        checkOutput("b2b first done", 16'(done), 16'd1);
        checkOutput("b2b first result", out, 16'h2341);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("b2b second busy", 16'(busy), 16'd1);
            checkOutput("b2b second done early", 16'(done), 16'd0);
            checkOutput("b2b out hold", out, 16'h2341);
        end
        @(negedge clk);
        checkOutput("b2b second done", 16'(done), 16'd1);
        checkOutput("b2b second result", out, 16'hFF00);
        last_out = 16'hFF00;
        @(negedge clk);
        checkOutput("b2b done pulse", 16'(done), 16'd0);
        checkOutput("b2b idle", 16'(busy), 16'd0);

        // Start pulse during SHIFT must be ignored.
        applyStimulus(16'h0F0F, 4'd4, 2'b10);
        @(negedge clk);
        in    = 16'hFFFF;
        cnt   = 4'd1;
        op    = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("ignore busy", 16'(busy), 16'd1);
        end
        @(negedge clk);
        checkOutput("ignore done", 16'(done), 16'd1);
        checkOutput("ignore result", out, 16'hF0F0);
        last_out = 16'hF0F0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("ignore no restart busy", 16'(busy), 16'd0);
            checkOutput("ignore no restart done", 16'(done), 16'd0);
        end

        // Asynchronous reset two cycles into an operation.
        applyStimulus(16'h1234, 4'd4, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 16'(busy), 16'd0);
        checkOutput("abort done", 16'(done), 16'd0);
        checkOutput("abort out", out, 16'h0000);
        last_out = 16'h0000;
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("abort no done", 16'(done_seen), 16'd0);
        checkOutput("abort idle busy", 16'(busy), 16'd0);
        runOp("after abort", 16'h00F0, 4'd3, 2'b01, 16'h0780);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
